// File: rtl/unified_mem.sv
// Unified instruction/data main memory: one request port, tagged fixed-latency load responses.
// Stores commit at acceptance; loads snapshot the aligned 64-bit line and return it MEM_LATENCY_CYCLES edges later.
module unified_mem #(
    parameter int XLEN               = 32,
    parameter int MEM_64BIT_LINES    = 8192,
    parameter int MEM_LATENCY_CYCLES = 10,
    parameter int NUM_MEM_TAGS       = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      proc2mem_command,
    input  logic [XLEN-1:0] proc2mem_addr,
    input  logic [63:0]     proc2mem_data,
    input  logic [1:0]      proc2mem_size,
    output logic [3:0]      mem2proc_response,
    output logic [63:0]     mem2proc_data,
    output logic [3:0]      mem2proc_tag
);

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2,
        BUS_RSVD  = 2'd3
    } bus_cmd_e;

    localparam int IDX_W = $clog2(MEM_64BIT_LINES);
    localparam int LAT   = MEM_LATENCY_CYCLES;

    logic [63:0] unified_memory [0:MEM_64BIT_LINES-1];

    logic [3:0]     next_tag;
    logic [15:0]    tag_busy;
    logic [15:0]    tag_busy_next;
    logic [LAT-1:0] pipe_valid;
    logic [3:0]     pipe_tag  [LAT];
    logic [63:0]    pipe_data [LAT];

    bus_cmd_e         cmd;
    logic             is_req;
    logic             in_range;
    logic             aligned;
    logic             accept;
    logic             load_commit;
    logic             store_commit;
    logic [2:0]       align_mask;
    logic [7:0]       lane_mask;
    logic [7:0]       byte_en;
    logic [63:0]      wdata;
    logic [IDX_W-1:0] line_idx;
    logic             fin_valid;
    logic [3:0]       fin_tag;

    assign cmd      = bus_cmd_e'(proc2mem_command);
    assign is_req   = (cmd == BUS_LOAD) || (cmd == BUS_STORE);
    assign in_range = {3'b000, proc2mem_addr[XLEN-1:3]} < XLEN'(MEM_64BIT_LINES);
    assign line_idx = proc2mem_addr[IDX_W+2:3];

    always_comb begin
        align_mask = 3'b000;
        lane_mask  = 8'h01;
        case (proc2mem_size)
            2'd0: begin align_mask = 3'b000; lane_mask = 8'h01; end
            2'd1: begin align_mask = 3'b001; lane_mask = 8'h03; end
            2'd2: begin align_mask = 3'b011; lane_mask = 8'h0F; end
            default: begin align_mask = 3'b111; lane_mask = 8'hFF; end
        endcase
    end

    assign aligned      = (proc2mem_addr[2:0] & align_mask) == 3'b000;
    assign accept       = reset && is_req && in_range && aligned && !tag_busy[next_tag];
    assign load_commit  = accept && (cmd == BUS_LOAD);
    assign store_commit = accept && (cmd == BUS_STORE);
    assign byte_en      = lane_mask << proc2mem_addr[2:0];
    assign wdata        = proc2mem_data << {proc2mem_addr[2:0], 3'b000};

    assign mem2proc_response = accept ? next_tag : 4'd0;
    assign mem2proc_tag      = pipe_valid[LAT-1] ? pipe_tag[LAT-1] : 4'd0;
    assign mem2proc_data     = pipe_valid[LAT-1] ? pipe_data[LAT-1] : 64'd0;

    // The entry moving into the last stage is delivered this edge, so its tag is released now.
    generate
        if (LAT == 1) begin : g_lat1
            assign fin_valid = load_commit;
            assign fin_tag   = next_tag;
        end else begin : g_latn
            assign fin_valid = pipe_valid[LAT-2];
            assign fin_tag   = pipe_tag[LAT-2];
        end
    endgenerate

    always_comb begin
        tag_busy_next = tag_busy;
        if (load_commit) tag_busy_next[next_tag] = 1'b1;
        if (fin_valid)   tag_busy_next[fin_tag]  = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            next_tag   <= 4'd1;
            tag_busy   <= '0;
            pipe_valid <= '0;
            for (int i = 0; i < LAT; i++) begin
                pipe_tag[i]  <= 4'd0;
                pipe_data[i] <= 64'd0;
            end
        end else begin
            tag_busy      <= tag_busy_next;
            pipe_valid[0] <= load_commit;
            pipe_tag[0]   <= load_commit ? next_tag : 4'd0;
            pipe_data[0]  <= load_commit ? unified_memory[line_idx] : 64'd0;
            for (int i = 1; i < LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_tag[i]   <= pipe_tag[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
            if (accept) next_tag <= (next_tag == 4'(NUM_MEM_TAGS)) ? 4'd1 : next_tag + 4'd1;
        end
    end

    // Contents are deliberately kept through reset so a preloaded program survives it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
        end else if (store_commit) begin
            for (int b = 0; b < 8; b++) begin
                if (byte_en[b]) unified_memory[line_idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_unified_mem.sv
// Self-checking bench for unified_mem: randomized traffic against a line-array / delivery-schedule model.
module tb_unified_mem;

    localparam int LAT = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  proc2mem_command = 2'd0;
    logic [31:0] proc2mem_addr = 32'd0;
    logic [63:0] proc2mem_data = 64'd0;
    logic [1:0]  proc2mem_size = 2'd0;
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;

    unified_mem dut (
        .clk               (clk),
        .reset             (reset),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .proc2mem_data     (proc2mem_data),
        .proc2mem_size     (proc2mem_size),
        .mem2proc_response (mem2proc_response),
        .mem2proc_data     (mem2proc_data),
        .mem2proc_tag      (mem2proc_tag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: line contents, tag counter, outstanding set, deliveries keyed by edge number.
    logic [63:0] mdl_mem [0:8191];
    int          mdl_next_tag = 1;
    bit          mdl_busy [16];
    int          edge_n = 0;
    int          due_tag [int];
    logic [63:0] due_data [int];

    int          r_got, r_exp, t_got, t_exp;
    logic [63:0] d_got, d_exp;

    task automatic cyc(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d, input logic [1:0] s);
        int line;
        bit ok;
        @(negedge clk);
        proc2mem_command = c;
        proc2mem_addr    = a;
        proc2mem_data    = d;
        proc2mem_size    = s;
        #1;
        line = int'(a >> 3);
        ok = (reset == 1'b1) && (c == 2'd1 || c == 2'd2) && (line < 8192) &&
             ((int'(a[2:0]) % (1 << s)) == 0) && !mdl_busy[mdl_next_tag];
        r_exp = ok ? mdl_next_tag : 0;
        r_got = int'(mem2proc_response);
        @(posedge clk);
        edge_n++;
        if (ok) begin
            if (c == 2'd1) begin
                due_tag[edge_n + LAT - 1]  = mdl_next_tag;
                due_data[edge_n + LAT - 1] = mdl_mem[line];
                mdl_busy[mdl_next_tag] = 1'b1;
            end else begin
                for (int b = 0; b < (1 << s); b++)
                    mdl_mem[line][(int'(a[2:0]) + b)*8 +: 8] = d[b*8 +: 8];
            end
            mdl_next_tag = (mdl_next_tag == 15) ? 1 : mdl_next_tag + 1;
        end
        if (due_tag.exists(edge_n)) begin
            t_exp = due_tag[edge_n];
            d_exp = due_data[edge_n];
            mdl_busy[t_exp] = 1'b0;
            due_tag.delete(edge_n);
            due_data.delete(edge_n);
        end else begin
            t_exp = 0;
            d_exp = 64'd0;
        end
        #1;
        t_got = int'(mem2proc_tag);
        d_got = mem2proc_data;
    endtask

    task automatic idle();
        cyc(2'd0, 32'd0, 64'd0, 2'd0);
    endtask

    task automatic reset_assert(input logic [1:0] c);
        @(negedge clk);
        proc2mem_command = c;
        proc2mem_addr    = 32'h10;
        proc2mem_size    = 2'd3;
        reset = 1'b0;
        due_tag.delete();
        due_data.delete();
        for (int i = 0; i < 16; i++) mdl_busy[i] = 1'b0;
        mdl_next_tag = 1;
        #1;
    endtask

    task automatic reset_release();
        repeat (2) begin
            @(posedge clk);
            edge_n++;
        end
        @(negedge clk);
        proc2mem_command = 2'd0;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset_assert(2'd1);
        checks++;
        if (mem2proc_response !== 4'd0) begin
            failures++; $display("FAIL reset_response got=%0d exp=0", mem2proc_response);
        end
        @(posedge clk); #1;
        checks++;
        if (mem2proc_tag !== 4'd0) begin
            failures++; $display("FAIL reset_tag got=%0d exp=0", mem2proc_tag);
        end
        checks++;
        if (mem2proc_data !== 64'd0) begin
            failures++; $display("FAIL reset_data got=%h exp=0", mem2proc_data);
        end
        reset_release();
    endtask

    task automatic test_preload_load();
        int seen_at = -1;
        logic [63:0] seen_data = 64'd0;
        for (int i = 0; i < 32; i++) begin
            cyc(2'd2, 32'(i*8), {$urandom, $urandom}, 2'd3);
            checks++;
            if (r_got !== r_exp) begin
                failures++; $display("FAIL preload_resp line=%0d got=%0d exp=%0d", i, r_got, r_exp);
            end
        end
        cyc(2'd2, 32'h10, 64'h1122334455667788, 2'd3);
        reset_assert(2'd0);
        reset_release();
        cyc(2'd1, 32'h10, 64'd0, 2'd3);
        checks++;
        if (r_got !== 1) begin
            failures++; $display("FAIL load_resp got=%0d exp=1", r_got);
        end
        for (int k = 1; k <= 15; k++) begin
            idle();
            checks++;
            if (t_got !== t_exp || d_got !== d_exp) begin
                failures++; $display("FAIL load_deliver k=%0d got=%0d/%h exp=%0d/%h", k, t_got, d_got, t_exp, d_exp);
            end
            if (t_got != 0) begin
                seen_at = k;
                seen_data = d_got;
            end
        end
        checks++;
        if (seen_at !== LAT - 1 || seen_data !== 64'h1122334455667788) begin
            failures++; $display("FAIL load_latency got=%0d/%h exp=%0d/1122334455667788", seen_at, seen_data, LAT - 1);
        end
    endtask

    task automatic test_byte_half();
        logic [63:0] got_line = 64'd0;
        reset_assert(2'd0);
        reset_release();
        cyc(2'd2, 32'h13, 64'hAB, 2'd0);
        checks++;
        if (r_got !== 1) begin failures++; $display("FAIL byte_store_resp got=%0d exp=1", r_got); end
        cyc(2'd2, 32'h16, 64'hCDEF, 2'd1);
        checks++;
        if (r_got !== 2) begin failures++; $display("FAIL half_store_resp got=%0d exp=2", r_got); end
        cyc(2'd1, 32'h10, 64'd0, 2'd3);
        checks++;
        if (r_got !== 3) begin failures++; $display("FAIL merge_load_resp got=%0d exp=3", r_got); end
        for (int k = 0; k < 12; k++) begin
            idle();
            checks++;
            if (t_got !== t_exp || d_got !== d_exp) begin
                failures++; $display("FAIL merge_deliver got=%0d/%h exp=%0d/%h", t_got, d_got, t_exp, d_exp);
            end
            if (t_got == 3) got_line = d_got;
        end
        checks++;
        if (got_line !== 64'hCDEF3344AB667788) begin
            failures++; $display("FAIL merge_data got=%h exp=cdef3344ab667788", got_line);
        end
    endtask

    task automatic test_reject();
        int tag0 = mdl_next_tag;
        int deliveries = 0;
        cyc(2'd1, 32'h11, 64'd0, 2'd1);
        checks++;
        if (r_got !== 0) begin failures++; $display("FAIL misaligned_resp got=%0d exp=0", r_got); end
        cyc(2'd1, 32'h10000, 64'd0, 2'd3);
        checks++;
        if (r_got !== 0) begin failures++; $display("FAIL out_of_range_resp got=%0d exp=0", r_got); end
        cyc(2'd1, 32'h8, 64'd0, 2'd3);
        checks++;
        if (r_got !== tag0) begin failures++; $display("FAIL reject_tag_hold got=%0d exp=%0d", r_got, tag0); end
        for (int k = 0; k < 12; k++) begin
            idle();
            checks++;
            if (t_got !== t_exp || d_got !== d_exp) begin
                failures++; $display("FAIL reject_deliver got=%0d/%h exp=%0d/%h", t_got, d_got, t_exp, d_exp);
            end
            if (t_got != 0) deliveries++;
        end
        checks++;
        if (deliveries !== 1) begin failures++; $display("FAIL reject_deliveries got=%0d exp=1", deliveries); end
    endtask

    task automatic test_back_to_back();
        int order [$];
        reset_assert(2'd0);
        reset_release();
        for (int i = 0; i < 16; i++) begin
            cyc(2'd1, 32'($urandom_range(0, 31) * 8), 64'd0, 2'd3);
            checks++;
            if (r_got !== ((i < 15) ? i + 1 : 1)) begin
                failures++; $display("FAIL b2b_resp i=%0d got=%0d exp=%0d", i, r_got, (i < 15) ? i + 1 : 1);
            end
            checks++;
            if (t_got !== t_exp || d_got !== d_exp) begin
                failures++; $display("FAIL b2b_deliver got=%0d/%h exp=%0d/%h", t_got, d_got, t_exp, d_exp);
            end
            if (t_got != 0) order.push_back(t_got);
        end
        for (int k = 0; k < 12; k++) begin
            idle();
            checks++;
            if (t_got !== t_exp || d_got !== d_exp) begin
                failures++; $display("FAIL b2b_drain got=%0d/%h exp=%0d/%h", t_got, d_got, t_exp, d_exp);
            end
            if (t_got != 0) order.push_back(t_got);
        end
        checks++;
        if (order.size() !== 16) begin
            failures++; $display("FAIL b2b_count got=%0d exp=16", order.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (order[i] !== ((i < 15) ? i + 1 : 1)) begin
                    failures++; $display("FAIL b2b_order i=%0d got=%0d exp=%0d", i, order[i], (i < 15) ? i + 1 : 1);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [63:0] v = {$urandom, $urandom};
        logic [63:0] got_line = 64'd0;
        int stray = 0;
        cyc(2'd2, 32'h28, v, 2'd3);
        cyc(2'd1, 32'h40, 64'd0, 2'd3);
        repeat (5) idle();
        reset_assert(2'd1);
        checks++;
        if (mem2proc_response !== 4'd0 || mem2proc_tag !== 4'd0) begin
            failures++; $display("FAIL midflight_reset_out got=%0d/%0d exp=0/0", mem2proc_response, mem2proc_tag);
        end
        reset_release();
        for (int k = 0; k < 12; k++) begin
            idle();
            if (t_got != 0) stray++;
        end
        checks++;
        if (stray !== 0) begin failures++; $display("FAIL midflight_stray got=%0d exp=0", stray); end
        cyc(2'd1, 32'h28, 64'd0, 2'd3);
        checks++;
        if (r_got !== 1) begin failures++; $display("FAIL midflight_tag got=%0d exp=1", r_got); end
        for (int k = 0; k < 12; k++) begin
            idle();
            if (t_got == 1) got_line = d_got;
        end
        checks++;
        if (got_line !== v) begin failures++; $display("FAIL midflight_store_kept got=%h exp=%h", got_line, v); end
    endtask

    task automatic test_store_no_completion();
        int stray = 0;
        cyc(2'd2, 32'($urandom_range(0, 31) * 8 + 4), {$urandom, $urandom}, 2'd2);
        checks++;
        if (r_got == 0 || r_got !== r_exp) begin
            failures++; $display("FAIL store_resp got=%0d exp=%0d", r_got, r_exp);
        end
        for (int k = 0; k < 20; k++) begin
            idle();
            if (t_got != 0) stray++;
        end
        checks++;
        if (stray !== 0) begin failures++; $display("FAIL store_completion got=%0d exp=0", stray); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            int line = ($urandom_range(0, 9) == 0) ? 8192 + $urandom_range(0, 50) : $urandom_range(0, 31);
            cyc(2'($urandom_range(0, 3)), 32'(line * 8 + $urandom_range(0, 7)), {$urandom, $urandom},
                2'($urandom_range(0, 3)));
            checks++;
            if (r_got !== r_exp) begin
                failures++; $display("FAIL rand_resp n=%0d got=%0d exp=%0d", n, r_got, r_exp);
            end
            checks++;
            if (t_got !== t_exp || d_got !== d_exp) begin
                failures++; $display("FAIL rand_deliver n=%0d got=%0d/%h exp=%0d/%h", n, t_got, d_got, t_exp, d_exp);
            end
        end
        for (int k = 0; k < 12; k++) begin
            idle();
            checks++;
            if (t_got !== t_exp || d_got !== d_exp) begin
                failures++; $display("FAIL rand_drain got=%0d/%h exp=%0d/%h", t_got, d_got, t_exp, d_exp);
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_preload_load();
        test_byte_half();
        test_reject();
        test_back_to_back();
        test_reset_midflight();
        test_store_no_completion();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unified_mem.md
# unified_mem

Behavioural-but-synthesizable main-memory model shared by instruction fetch and data access of the `processor` core.
- Presents a single request port, `proc2mem_*`, and a tagged, fixed-latency response port, `mem2proc_*`.
- Stores take effect at acceptance. Loads return an aligned 64-bit line after a fixed delay.
- Contents are preloadable by hierarchical `$readmemh` into `unified_memory` and dumpable from the same array.

## Interface
- `XLEN`, default 32: address width.
- `MEM_64BIT_LINES`, default 8192: number of 64-bit lines (64 KiB).
- `MEM_LATENCY_CYCLES`, default 10: clock edges from load acceptance to data return; legal range 1..31.
- `NUM_MEM_TAGS`, default 15: tag values are 1..15; 0 means none/rejected.
- Storage array: `unified_memory[0:MEM_64BIT_LINES-1]`, each 64 bits, addressed by `addr[XLEN-1:3]`.

Ports:
- `clk` — in, 1 — sole clock; all state is updated on the rising edge.
- `reset` — in, 1 — reset is asynchronous and active-low.
- `proc2mem_command` — in, 2 — 0 = BUS_NONE, 1 = BUS_LOAD, 2 = BUS_STORE, 3 = reserved (treated as NONE).
- `proc2mem_addr` — in, XLEN — byte address.
- `proc2mem_data` — in, 64 — store data, right-justified.
- `proc2mem_size` — in, 2 — 0 = BYTE, 1 = HALF, 2 = WORD, 3 = DOUBLE.
- `mem2proc_response` — out, 4 — tag granted to the current request; 0 = not accepted.
- `mem2proc_data` — out, 64 — load data returned this cycle.
- `mem2proc_tag` — out, 4 — tag of the load completing this cycle; 0 = none.

## Operation
- **Acceptance** (combinational from inputs and state): `mem2proc_response = next_tag` when all of the following hold; otherwise 0.
  - The command is LOAD or STORE.
  - `addr[XLEN-1:3] < MEM_64BIT_LINES`.
  - `addr[2:0]` is a multiple of 2^size (naturally aligned).
  - `next_tag` is not outstanding.
- The request is committed at the next rising edge only if the response was nonzero.
- **Tag counter `next_tag`:**
  - Reset value 1.
  - Advances on every accepted request (load or store).
  - Wraps from 15 to 1; 0 is never issued.
- **Load:**
  - Snapshots line `unified_memory[addr>>3]` at the accepting edge.
  - The full aligned line is returned regardless of size; the core extracts bytes.
  - The tag is marked outstanding until delivery.
- **Store:**
  - Writes only the addressed bytes at the accepting edge: lane `addr[2:0]` upward, 2^size bytes, taken from `proc2mem_data` low bytes.
  - Other bytes of the line are unchanged.
  - The tag is issued but never becomes outstanding and never appears on `mem2proc_tag`.
- **Delivery:**
  - Exactly `MEM_LATENCY_CYCLES` edges after acceptance, `mem2proc_tag` shows the tag and `mem2proc_data` shows the snapshot, for one cycle.
  - The tag is freed at that edge.
  - At most one load is accepted per cycle, so at most one delivery occurs per cycle.
- **Load after store to the same line:** the load accepted in a later cycle sees the stored bytes. Same-cycle requests are impossible (single port).
- **Idle outputs:** `mem2proc_tag = 0` and `mem2proc_data = 0` when no delivery is due.
- **Outstanding capacity:** with latency ≤ 15, tag exhaustion cannot occur. With latency > 15, requests are rejected while `next_tag` is busy; the counter does not advance on rejection.

## Timing
- `mem2proc_response` is valid in the same cycle as the request (combinational). The requester holds the request until it sees a nonzero response.
- Delivery pipeline is a `MEM_LATENCY_CYCLES`-deep shift register of {valid, tag, data}. Outputs are driven from its final stage (registered).
- **Reset asserted (low), asynchronously:**
  - Pipeline valids cleared.
  - All tags freed.
  - `next_tag` = 1.
  - `mem2proc_tag` = 0 and `mem2proc_data` = 0.
  - `mem2proc_response` forced to 0.
  - `unified_memory` is NOT cleared, so a program preload survives reset.
- **Reset mid-operation:** in-flight loads are discarded with no delivery. Stores already committed remain in memory.

## Test plan
- **Preload and load.** Preload line 2 = 0x1122334455667788. With reset high, issue LOAD addr 0x10 size DOUBLE.
  - Response = 1 in the same cycle.
  - Exactly 10 edges later, tag = 1 and data = 0x1122334455667788 for one cycle; otherwise tag = 0.
- **Byte and half stores.** Over line 2 = 0x1122334455667788: STORE addr 0x13 BYTE data 0xAB, then STORE addr 0x16 HALF data 0xCDEF.
  - A subsequent load of 0x10 returns 0xCDEF3344AB667788.
  - Responses are 1, 2, 3 in that order.
- **Misaligned or out-of-range rejection.**
  - LOAD addr 0x11 HALF → response 0.
  - LOAD addr 0x10000 → response 0.
  - In both cases `next_tag` is unchanged and no delivery occurs.
- **Back-to-back loads and tag wrap.** 16 back-to-back loads return responses 1..15, 1.
  - Deliveries occur on consecutive cycles starting 10 edges after the first, in the same order, each with correct data.
- **Reset mid-flight.** Pull reset low 5 cycles after a LOAD.
  - The pending delivery never appears.
  - After release, the next request gets tag 1.
  - A store committed before reset is still readable.
- **Store has no completion.** A STORE gets nonzero response and `mem2proc_tag` stays 0 for the following 20 cycles.
